// File: rtl/mandel_pixel_source.sv
// ============================================================================
// mandel_pixel_source
//   Raster timing generator, iteration-count FIFO, palette and frame lock for
//   the HDMI/DVI output path.
//   Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mandel_pixel_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int FIFO_AW  = 4
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [ITER_W-1:0] pix_iter,
    input  logic              pix_sof,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start,
    output logic              underflow,
    output logic              locked
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int EW      = ITER_W + 1;

    localparam logic [HW-1:0]    c_H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    c_HS_BEG   = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0]    c_HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0]    c_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    c_V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    c_VS_BEG   = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0]    c_VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0]    c_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [FIFO_AW:0] c_DEPTH    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [31:0]      c_MAX_ITER = 32'(MAX_ITER);

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    logic w_active, w_at00;
    assign w_active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_at00   = (r_h_cnt == '0) && (r_v_cnt == '0);

    // FWFT FIFO: full/empty come from the registered count, so a pop never
    // frees a slot (nor a push fills an empty head) within the same cycle.
    logic [EW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_full, w_empty, w_push, w_pop;
    logic [EW-1:0]      w_head;
    logic               w_head_sof;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign pix_ready  = !w_full && !reset;
    assign w_push     = pix_valid && pix_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sof = w_head[ITER_W];

    always_ff @(posedge pixel_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pix_sof, pix_iter};
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    state_t r_state, w_state_nxt;
    logic   w_show, w_uf;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_show      = 1'b0;
        w_uf        = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                if (!w_empty) begin
                    if (!w_head_sof) begin
                        w_pop = 1'b1;
                    end else if (w_at00) begin
                        w_pop       = 1'b1;
                        w_show      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_active) begin
                    if (w_empty) begin
                        w_uf = 1'b1;
                    end else if (w_head_sof && !w_at00) begin
                        // leave the sof entry at the head for the next frame
                        w_state_nxt = ST_WAIT_SOF;
                    end else if (!w_head_sof && w_at00) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_WAIT_SOF;
                    end else begin
                        w_pop  = 1'b1;
                        w_show = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_SOF;
        endcase
    end

    logic       r1_de, r1_hs, r1_vs, r1_fs, r1_uf, r1_lock, r1_show;
    logic [7:0] r1_it;
    logic       w_inset;

    assign w_inset = ({24'd0, r1_it} == c_MAX_ITER);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WAIT_SOF;
            r1_de       <= 1'b0;
            r1_hs       <= 1'b1;
            r1_vs       <= 1'b1;
            r1_fs       <= 1'b0;
            r1_uf       <= 1'b0;
            r1_lock     <= 1'b0;
            r1_show     <= 1'b0;
            r1_it       <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r1_de       <= w_active;
            r1_hs       <= !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
            r1_vs       <= !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
            r1_fs       <= w_at00;
            r1_uf       <= w_uf;
            r1_lock     <= (w_state_nxt == ST_RUN);
            r1_show     <= w_show;
            r1_it       <= w_head[7:0];
            hsync       <= r1_hs;
            vsync       <= r1_vs;
            de          <= r1_de;
            frame_start <= r1_fs;
            underflow   <= r1_uf;
            locked      <= r1_lock;
            if (r1_show && !w_inset) begin
                red   <= r1_it;
                green <= {r1_it[6:0], 1'b0};
                blue  <= ~r1_it;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mandel_pixel_source.sv
// ============================================================================
// tb_mandel_pixel_source
//   Scoreboard bench for mandel_pixel_source on a reduced raster.
//   Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandel_pixel_source;

    localparam int H_A = 16, H_F = 2, H_S = 4, H_B = 2;
    localparam int V_A = 8,  V_F = 1, V_S = 2, V_B = 2;
    localparam int H_T = H_A + H_F + H_S + H_B;
    localparam int V_T = V_A + V_F + V_S + V_B;
    localparam int FT = H_T * V_T;
    localparam int DEPTH = 16;

    logic       pixel_clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_iter = 8'd0;
    logic       pix_ready;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, de, frame_start, underflow, locked;

    mandel_pixel_source #(
        .H_ACTIVE(H_A), .H_FRONT(H_F), .H_SYNC(H_S), .H_BACK(H_B),
        .V_ACTIVE(V_A), .V_FRONT(V_F), .V_SYNC(V_S), .V_BACK(V_B),
        .ITER_W(8), .MAX_ITER(255), .FIFO_AW(4)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_iter(pix_iter), .pix_sof(pix_sof),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .underflow(underflow), .locked(locked)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int          mh = 0, mv = 0;
    bit          mrun = 0, acc = 0;
    logic [8:0]  mq[$];
    logic [29:0] exp_q[$];
    int          cyc = 0, last_fs = -1, de_cnt = 0, uf_seen = 0, lock_rises = 0;
    bit          prev_lock = 0;

    task automatic model_step();
        bit         act, z, pop, show, uf, empty, hs, vs;
        logic [8:0] hd;
        logic [7:0] r, g, b;
        act   = (mh < H_A) && (mv < V_A);
        z     = (mh == 0) && (mv == 0);
        pop   = 0; show = 0; uf = 0;
        empty = (mq.size() == 0);
        hd    = 9'd0;
        if (!empty) hd = mq[0];
        if (!mrun) begin
            if (!empty) begin
                if (!hd[8]) pop = 1;
                else if (z) begin pop = 1; show = 1; mrun = 1; end
            end
        end else if (act) begin
            if (empty) uf = 1;
            else if (hd[8] != z) begin mrun = 0; pop = !hd[8]; end
            else begin pop = 1; show = 1; end
        end
        acc = pix_valid && (mq.size() < DEPTH);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({pix_sof, pix_iter});
        r = 8'd0; g = 8'd0; b = 8'd0;
        if (show && hd[7:0] != 8'hFF) begin
            r = hd[7:0];
            g = {hd[6:0], 1'b0};
            b = ~hd[7:0];
        end
        hs = !((mh >= H_A + H_F) && (mh < H_A + H_F + H_S));
        vs = !((mv >= V_A + V_F) && (mv < V_A + V_F + V_S));
        exp_q.push_back({r, g, b, hs, vs, act, z, uf, mrun});
        mh++;
        if (mh == H_T) begin
            mh = 0;
            mv++;
            if (mv == V_T) mv = 0;
        end
    endtask

    always @(posedge pixel_clk) begin
        logic [29:0] e;
        cyc++;
        if (reset) begin
            mh = 0; mv = 0; mrun = 0; acc = 0;
            mq.delete();
            exp_q.delete();
            last_fs = -1; de_cnt = 0;
        end else begin
            model_step();
        end
        #1;
        check("ready", {31'd0, pix_ready}, {31'd0, !reset && (mq.size() < DEPTH)});
        if (!reset && exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("pixel", {2'b00, red, green, blue, hsync, vsync, de, frame_start, underflow, locked},
                  {2'b00, e});
            if (frame_start) begin
                if (last_fs >= 0) begin
                    check("fs_period", cyc - last_fs, FT);
                    check("de_per_frame", de_cnt, H_A * V_A);
                end
                last_fs = cyc;
                de_cnt  = 0;
            end
            if (de) de_cnt++;
            if (underflow) uf_seen++;
            if (locked && !prev_lock) lock_rises++;
            prev_lock = locked;
        end
    end

    task automatic send(input bit s, input int it);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_sof   = s;
        pix_iter  = it[7:0];
        do begin
            @(posedge pixel_clk);
            #2;
            n++;
        end while (!acc && n < 4 * FT);
        check("send_acc", {31'd0, acc}, 32'd1);
        pix_valid = 1'b0;
    endtask

    task automatic feed_frame(input int gap_at, input int gap_len, input int sof2_at);
        for (int i = 0; i < H_A * V_A; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) @(posedge pixel_clk);
                #2;
            end
            send(i == 0 || i == sof2_at, (i == 10) ? 255 : i);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < 2 * FT) begin
            @(negedge pixel_clk);
            n++;
        end
        check("wait_pos", {31'd0, n < 2 * FT}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge pixel_clk);
        #1;
        check("rst_out", {2'b00, red, green, blue, hsync, vsync, de, frame_start, underflow, locked},
              32'h0000_0030);
        check("rst_ready", {31'd0, pix_ready}, 32'd0);
        @(negedge pixel_clk);
        reset = 1'b0;

        // idle raster, then aligned streaming with backpressure
        repeat (2 * FT + 5) @(negedge pixel_clk);
        feed_frame(-1, 0, -1);
        feed_frame(-1, 0, -1);
        // starvation mid-line, then an out-of-place sof, then relock
        feed_frame(40, 60, -1);
        feed_frame(-1, 0, 50);
        feed_frame(-1, 0, -1);
        feed_frame(-1, 0, -1);
        repeat (FT) @(negedge pixel_clk);
        check("uf_seen", {31'd0, uf_seen > 0}, 32'd1);
        check("relock", {31'd0, lock_rises >= 2}, 32'd1);

        // park a sof entry in the FIFO, then reset mid-frame
        wait_pos(3, 2);
        send(1'b1, 7);
        wait_pos(12, 4);
        reset = 1'b1;
        #1;
        check("midrst_out", {2'b00, red, green, blue, hsync, vsync, de, frame_start, underflow, locked},
              32'h0000_0030);
        check("midrst_ready", {31'd0, pix_ready}, 32'd0);
        repeat (3) @(negedge pixel_clk);
        reset = 1'b0;
        repeat (2 * FT + 10) @(negedge pixel_clk);
        check("post_rst_unlocked", {31'd0, locked}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
